// File: rtl/bit_order_deserializer.sv
// Serial-to-parallel word assembler with selectable bit order and a
// one-entry valid/ready output buffer that flags dropped words.
module bit_order_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     bit_in,
  input  logic                     bit_valid,
  output logic [WIDTH-1:0]         word_out,
  output logic                     word_valid,
  input  logic                     word_ready,
  output logic                     overflow,
  output logic [$clog2(WIDTH)-1:0] bit_count
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shift_next;
  logic             complete;
  logic             load;
  logic             drop;

  assign complete   = bit_valid && !clear && (bit_count == LAST);
  assign word_valid = (state == FULL);

  // The completed word includes the bit arriving on the completing edge.
  generate
    if (MSB_FIRST) begin : g_msb
      assign shift_next = {shift_reg[WIDTH-2:0], bit_in};
    end else begin : g_lsb
      assign shift_next = {bit_in, shift_reg[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    state_next = state;
    load       = 1'b0;
    drop       = 1'b0;
    if (clear) begin
      state_next = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (complete) begin
            load       = 1'b1;
            state_next = FULL;
          end
        end
        FULL: begin
          if (complete) begin
            // A simultaneous handshake frees the slot for the new word.
            if (word_ready) load = 1'b1;
            else            drop = 1'b1;
          end else if (word_ready) begin
            state_next = EMPTY;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
      bit_count <= '0;
      word_out  <= '0;
      overflow  <= 1'b0;
    end else if (clear) begin
      shift_reg <= '0;
      bit_count <= '0;
      overflow  <= 1'b0;
    end else begin
      if (bit_valid) begin
        shift_reg <= shift_next;
        bit_count <= complete ? '0 : bit_count + CW'(1);
      end
      if (load) word_out <= shift_next;
      if (drop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bit_order_deserializer.sv
// Self-checking bench: two instances (MSB-first and LSB-first) share inputs and
// are compared every cycle against a word-level reference model.
module tb_bit_order_deserializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         clear;
  logic         bit_in;
  logic         bit_valid;
  logic         word_ready;
  logic [W-1:0] word_out_m;
  logic [W-1:0] word_out_l;
  logic         word_valid_m;
  logic         word_valid_l;
  logic         overflow_m;
  logic         overflow_l;
  logic [2:0]   bit_count_m;
  logic [2:0]   bit_count_l;

  int errors = 0;
  int checks = 0;

  // Reference model state: bits of the current partial word, in arrival order.
  bit           bitsQ[$];
  logic [W-1:0] expWordM;
  logic [W-1:0] expWordL;
  logic         expValid;
  logic         expOvf;

  bit_order_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dutMsb (
    .clk(clk), .rst_n(rst_n), .clear(clear), .bit_in(bit_in), .bit_valid(bit_valid),
    .word_out(word_out_m), .word_valid(word_valid_m), .word_ready(word_ready),
    .overflow(overflow_m), .bit_count(bit_count_m)
  );

  bit_order_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dutLsb (
    .clk(clk), .rst_n(rst_n), .clear(clear), .bit_in(bit_in), .bit_valid(bit_valid),
    .word_out(word_out_l), .word_valid(word_valid_l), .word_ready(word_ready),
    .overflow(overflow_l), .bit_count(bit_count_l)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Word value from the first W arrival-ordered bits for either bit order.
  function automatic logic [W-1:0] assemble(input bit msbFirst);
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < W; i++) begin
      if (msbFirst) w[W-1-i] = bitsQ[i];
      else          w[i]     = bitsQ[i];
    end
    return w;
  endfunction

  function automatic void modelReset();
    bitsQ.delete();
    expWordM = '0;
    expWordL = '0;
    expValid = 1'b0;
    expOvf   = 1'b0;
  endfunction

  function automatic void modelEdge(input bit b, input bit v, input bit r, input bit c);
    bit done;
    if (c) begin
      bitsQ.delete();
      expValid = 1'b0;
      expOvf   = 1'b0;
      return;
    end
    done = 1'b0;
    if (v) begin
      bitsQ.push_back(b);
      if (bitsQ.size() == W) done = 1'b1;
    end
    if (done) begin
      if (expValid && !r) begin
        expOvf = 1'b1;
      end else begin
        expWordM = assemble(1'b1);
        expWordL = assemble(1'b0);
        expValid = 1'b1;
      end
      bitsQ.delete();
    end else if (expValid && r) begin
      expValid = 1'b0;
    end
  endfunction

  task automatic checkOutput(input string tag);
    check({tag, ".count_m"}, 32'(bit_count_m), 32'(bitsQ.size()));
    check({tag, ".count_l"}, 32'(bit_count_l), 32'(bitsQ.size()));
    check({tag, ".valid_m"}, 32'(word_valid_m), 32'(expValid));
    check({tag, ".valid_l"}, 32'(word_valid_l), 32'(expValid));
    check({tag, ".ovf_m"},   32'(overflow_m),   32'(expOvf));
    check({tag, ".ovf_l"},   32'(overflow_l),   32'(expOvf));
    check({tag, ".word_m"},  32'(word_out_m),   32'(expWordM));
    check({tag, ".word_l"},  32'(word_out_l),   32'(expWordL));
  endtask

  task automatic applyStimulus(input bit b, input bit v, input bit r, input bit c, input string tag);
    bit_in     = b;
    bit_valid  = v;
    word_ready = r;
    clear      = c;
    @(posedge clk);
    #1;
    modelEdge(b, v, r, c);
    checkOutput(tag);
  endtask

  task automatic sendByte(input logic [7:0] value, input bit r, input int maxGap, input string tag);
    for (int i = 7; i >= 0; i--) begin
      applyStimulus(value[i], 1'b1, r, 1'b0, tag);
      if (maxGap > 0 && i > 0) begin
        int gap;
        gap = $urandom_range(maxGap, 1);
        for (int g = 0; g < gap; g++) applyStimulus(1'b0, 1'b0, r, 1'b0, {tag, ".gap"});
      end
    end
  endtask

  task automatic pulseReset(input string tag);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput(tag);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n      = 1'b0;
    clear      = 1'b0;
    bit_in     = 1'b0;
    bit_valid  = 1'b0;
    word_ready = 1'b0;
    modelReset();
    #2;
    checkOutput("reset");
    #10;
    rst_n = 1'b1;

    // Plan 1/2: 0,0,1,1,0,1,0,1 back-to-back, ready high.
    sendByte(8'h35, 1'b1, 0, "t1");
    check("t1.word35", 32'(word_out_m), 32'h35);
    check("t1.wordAC", 32'(word_out_l), 32'hAC);
    check("t1.valid",  32'(word_valid_m), 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, "t1.drain");
    check("t1.drop", 32'(word_valid_m), 32'h0);

    // Plan 3: gapped bits.
    sendByte(8'h35, 1'b1, 3, "t3");
    check("t3.word35", 32'(word_out_m), 32'h35);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, "t3.drain");

    // Plan 4: overflow with ready low.
    sendByte(8'h35, 1'b0, 0, "t4a");
    sendByte(8'hFF, 1'b0, 0, "t4b");
    check("t4.keep35", 32'(word_out_m), 32'h35);
    check("t4.ovf",    32'(overflow_m), 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, "t4.accept");
    check("t4.ovfStays", 32'(overflow_m), 32'h1);
    check("t4.validDrop", 32'(word_valid_m), 32'h0);

    // Plan 5: ready on the completing cycle only.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, "t5.clear");
    sendByte(8'h35, 1'b0, 0, "t5a");
    for (int i = 7; i >= 1; i--) applyStimulus(i < 4, 1'b1, 1'b0, 1'b0, "t5b");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, "t5.last");
    check("t5.word0F", 32'(word_out_m), 32'h0F);
    check("t5.valid",  32'(word_valid_m), 32'h1);
    check("t5.noOvf",  32'(overflow_m), 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, "t5.drain");

    // Plan 6: partial word flushed by clear, then by reset.
    sendByte(8'hFF, 1'b1, 0, "t6.fill");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, "t6.drain");
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, "t6.part");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, "t6.clear");
    check("t6.cnt0", 32'(bit_count_m), 32'h0);
    sendByte(8'h35, 1'b1, 0, "t6.after");
    check("t6.word35", 32'(word_out_m), 32'h35);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, "t6.part2");
    pulseReset("t6.reset");
    check("t6.cntRst", 32'(bit_count_m), 32'h0);
    sendByte(8'h35, 1'b1, 0, "t6.afterRst");
    check("t6.word35r", 32'(word_out_m), 32'h35);

    // Randomized traffic with occasional clear and reset.
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(199, 0) == 0) pulseReset("rnd.reset");
      applyStimulus(1'($urandom), $urandom_range(3, 0) != 0, $urandom_range(2, 0) == 0,
                    $urandom_range(59, 0) == 0, "rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
